// File: rtl/quiz_pkg.sv
// Shared types and constants for the quiz round controller.
// Holds the FSM state encoding, datapath widths and the score ceiling.
package quiz_pkg;

    localparam int ANS_W = 8;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] SCORE_MAX = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_ARM    = 3'd2,
        S_RUN    = 3'd3,
        S_RESULT = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // Score counter that sticks at its ceiling instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == SCORE_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/quiz_round_ctrl.sv
// Round sequencer for a number-conversion quiz: fetches a question, runs the
// countdown, judges the answer, shows the result and tracks score and round.
module quiz_round_ctrl
    import quiz_pkg::*;
#(
    parameter int NUM_ROUNDS = 10,
    parameter int HOLD_CYC   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             submit,
    input  logic [ANS_W-1:0] answer,
    input  logic [ANS_W-1:0] question,
    input  logic [CNT_W-1:0] time_left,
    output logic             q_req,
    output logic             timer_reset,
    output logic             stop_flag,
    output logic [CNT_W-1:0] score,
    output logic [CNT_W-1:0] round,
    output logic             correct,
    output logic             wrong,
    output logic             timeout,
    output logic             game_over,
    output state_t           dbg_state
);

    localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(NUM_ROUNDS - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);

    state_t           state_q;
    logic [ANS_W-1:0] target_q;
    logic [CNT_W-1:0] hold_q;
    logic [CNT_W-1:0] score_q;
    logic [CNT_W-1:0] round_q;
    logic             q_req_q;
    logic             timer_reset_q;
    logic             stop_flag_q;
    logic             correct_q;
    logic             wrong_q;
    logic             timeout_q;
    logic             game_over_q;

    // Outputs are written alongside the state transition so each one is
    // already valid in the first cycle of the state it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            target_q      <= '0;
            hold_q        <= '0;
            score_q       <= '0;
            round_q       <= '0;
            q_req_q       <= 1'b0;
            timer_reset_q <= 1'b0;
            stop_flag_q   <= 1'b1;
            correct_q     <= 1'b0;
            wrong_q       <= 1'b0;
            timeout_q     <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    stop_flag_q <= 1'b1;
                    if (start) begin
                        state_q       <= S_REQ;
                        q_req_q       <= 1'b1;
                        timer_reset_q <= 1'b1;
                    end
                end

                S_REQ: begin
                    state_q       <= S_ARM;
                    q_req_q       <= 1'b0;
                    timer_reset_q <= 1'b1;
                    stop_flag_q   <= 1'b1;
                end

                S_ARM: begin
                    // The generator answers q_req one cycle late, so sample here.
                    target_q      <= question;
                    state_q       <= S_RUN;
                    timer_reset_q <= 1'b0;
                    stop_flag_q   <= 1'b0;
                end

                S_RUN: begin
                    if (submit) begin
                        if (answer == target_q) begin
                            correct_q <= 1'b1;
                            score_q   <= sat_inc(score_q);
                        end else begin
                            wrong_q <= 1'b1;
                        end
                        state_q     <= S_RESULT;
                        stop_flag_q <= 1'b1;
                        hold_q      <= HOLD_LOAD;
                    end else if (time_left == '0) begin
                        timeout_q   <= 1'b1;
                        state_q     <= S_RESULT;
                        stop_flag_q <= 1'b1;
                        hold_q      <= HOLD_LOAD;
                    end
                end

                S_RESULT: begin
                    stop_flag_q <= 1'b1;
                    if (hold_q == '0) begin
                        correct_q <= 1'b0;
                        wrong_q   <= 1'b0;
                        timeout_q <= 1'b0;
                        if (round_q == LAST_ROUND) begin
                            state_q     <= S_DONE;
                            game_over_q <= 1'b1;
                        end else begin
                            round_q       <= round_q + 1'b1;
                            state_q       <= S_REQ;
                            q_req_q       <= 1'b1;
                            timer_reset_q <= 1'b1;
                        end
                    end else begin
                        hold_q <= hold_q - 1'b1;
                    end
                end

                S_DONE: begin
                    stop_flag_q <= 1'b1;
                    if (start) begin
                        score_q       <= '0;
                        round_q       <= '0;
                        game_over_q   <= 1'b0;
                        state_q       <= S_REQ;
                        q_req_q       <= 1'b1;
                        timer_reset_q <= 1'b1;
                    end
                end

                default: begin
                    state_q     <= S_IDLE;
                    stop_flag_q <= 1'b1;
                end
            endcase
        end
    end

    assign q_req       = q_req_q;
    assign timer_reset = timer_reset_q;
    assign stop_flag   = stop_flag_q;
    assign score       = score_q;
    assign round       = round_q;
    assign correct     = correct_q;
    assign wrong       = wrong_q;
    assign timeout     = timeout_q;
    assign game_over   = game_over_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Self-checking bench for quiz_round_ctrl: table-driven rounds with a result
// scoreboard, plus hand-written game-over, restart and reset-in-result sequences.
module tb_quiz_round_ctrl;
    import quiz_pkg::*;

    localparam int NUM_ROUNDS = 10;
    localparam int HOLD_CYC   = 3;

    logic       clk = 1'b0;
    logic       reset, start, submit;
    logic [7:0] answer, question;
    logic [3:0] time_left;
    logic       q_req, timer_reset, stop_flag;
    logic [3:0] score, round;
    logic       correct, wrong, timeout, game_over;
    state_t     dbg_state;

    quiz_round_ctrl #(.NUM_ROUNDS(NUM_ROUNDS), .HOLD_CYC(HOLD_CYC)) dut (
        .clk(clk), .reset(reset), .start(start), .submit(submit),
        .answer(answer), .question(question), .time_left(time_left),
        .q_req(q_req), .timer_reset(timer_reset), .stop_flag(stop_flag),
        .score(score), .round(round), .correct(correct), .wrong(wrong),
        .timeout(timeout), .game_over(game_over), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // One round: question, answer, RUN cycle of the submit (-1 = never),
    // timer load, expected {correct,wrong,timeout} and score after the round.
    typedef struct {
        logic [7:0] question;
        logic [7:0] answer;
        int         sub_dly;
        logic [3:0] tl_load;
        logic [2:0] exp_flags;
        logic [3:0] exp_score;
    } vec_t;

    vec_t       vecs[NUM_ROUNDS];
    vec_t       vall[NUM_ROUNDS];
    logic [6:0] exp_q[$];
    logic [6:0] sb_e;
    logic [2:0] prev_flags = 3'b000;
    int         n_vec = 0;
    int         n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pop one expected result each time a result appears.
    always @(posedge clk) begin
        #1;
        if ({correct, wrong, timeout} != 3'b000 && prev_flags == 3'b000) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_result", {29'd0, correct, wrong, timeout}, 32'd0);
            end else begin
                sb_e = exp_q.pop_front();
                chk("sb_flags", {29'd0, correct, wrong, timeout}, {29'd0, sb_e[6:4]});
                chk("sb_score", {28'd0, score}, {28'd0, sb_e[3:0]});
            end
        end
        prev_flags <= {correct, wrong, timeout};
    end

    // Entered with the DUT in REQ; returns in the next REQ, in DONE, or (when
    // rst_in_result is set) in the first RESULT cycle.
    task automatic play_round(input vec_t v, input int idx, input bit rst_in_result);
        logic [3:0] tl;
        bit         done;
        int         hold;
        chk("req_q_req", {31'd0, q_req}, 32'd1);
        chk("req_round", {28'd0, round}, idx);
        chk("req_timer_reset", {31'd0, timer_reset}, 32'd1);
        question  = v.question;
        time_left = v.tl_load;
        submit    = 1'b0;
        start     = 1'b0;
        tick;
        chk("arm_q_req", {31'd0, q_req}, 32'd0);
        chk("arm_timer_reset", {31'd0, timer_reset}, 32'd1);
        chk("arm_stop_flag", {31'd0, stop_flag}, 32'd1);
        submit = 1'b1;
        answer = ~v.question;
        tick;
        submit   = 1'b0;
        question = 8'($urandom_range(0, 255));
        chk("run_stop_flag", {31'd0, stop_flag}, 32'd0);
        chk("run_timer_reset", {31'd0, timer_reset}, 32'd0);
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (c >= int'(v.tl_load)) tl = 4'd0;
            else tl = 4'(int'(v.tl_load) - c);
            time_left = tl;
            answer    = v.answer;
            submit    = (c == v.sub_dly);
            start     = 1'($urandom_range(0, 1));
            if (submit || tl == 4'd0) begin
                exp_q.push_back({v.exp_flags, v.exp_score});
                done = 1'b1;
            end
            tick;
            submit = 1'b0;
            start  = 1'b0;
            if (!done) chk("run_still_running", {31'd0, stop_flag}, 32'd0);
        end
        chk("res_stop_flag", {31'd0, stop_flag}, 32'd1);
        chk("res_flags", {29'd0, correct, wrong, timeout}, {29'd0, v.exp_flags});
        if (rst_in_result) return;
        hold = 0;
        while ({correct, wrong, timeout} != 3'b000 && hold < 20) begin
            hold++;
            if (stop_flag !== 1'b1) chk("res_hold_stop_flag", {31'd0, stop_flag}, 32'd1);
            tick;
        end
        chk("res_hold_cycles", hold, HOLD_CYC);
        chk("res_flags_cleared", {29'd0, correct, wrong, timeout}, 32'd0);
        if (idx == NUM_ROUNDS - 1) begin
            chk("end_game_over", {31'd0, game_over}, 32'd1);
            chk("end_q_req", {31'd0, q_req}, 32'd0);
        end else begin
            chk("next_q_req", {31'd0, q_req}, 32'd1);
            chk("next_round", {28'd0, round}, idx + 1);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        submit    = 1'b0;
        answer    = 8'h00;
        question  = 8'h00;
        time_left = 4'hF;
        tick;
        tick;
        chk("rst_stop_flag", {31'd0, stop_flag}, 32'd1);
        chk("rst_timer_reset", {31'd0, timer_reset}, 32'd0);
        chk("rst_q_req", {31'd0, q_req}, 32'd0);
        chk("rst_score", {28'd0, score}, 32'd0);
        chk("rst_round", {28'd0, round}, 32'd0);
        chk("rst_flags", {29'd0, correct, wrong, timeout}, 32'd0);
        chk("rst_game_over", {31'd0, game_over}, 32'd0);
        reset  = 1'b0;
        submit = 1'b1;
        tick;
        submit = 1'b0;
        chk("idle_q_req", {31'd0, q_req}, 32'd0);
        chk("idle_stop_flag", {31'd0, stop_flag}, 32'd1);

        vecs[0] = '{8'h2A, 8'h2A,  1, 4'd9, 3'b100, 4'd1};
        vecs[1] = '{8'h05, 8'h50,  2, 4'd9, 3'b010, 4'd1};
        vecs[2] = '{8'h77, 8'h00, -1, 4'd3, 3'b001, 4'd1};
        vecs[3] = '{8'hC3, 8'hC3,  2, 4'd2, 3'b100, 4'd2};
        vecs[4] = '{8'hFF, 8'hFF,  0, 4'd5, 3'b100, 4'd3};
        vecs[5] = '{8'h00, 8'h00,  3, 4'd7, 3'b100, 4'd4};
        vecs[6] = '{8'h80, 8'h81,  1, 4'd4, 3'b010, 4'd4};
        vecs[7] = '{8'h01, 8'h01, -1, 4'd1, 3'b001, 4'd4};
        vecs[8] = '{8'h7E, 8'h7E,  4, 4'd6, 3'b100, 4'd5};
        vecs[9] = '{8'hAA, 8'h55,  0, 4'd0, 3'b010, 4'd5};
        for (int i = 0; i < NUM_ROUNDS; i++) begin
            vall[i].question  = 8'($urandom_range(0, 255));
            vall[i].answer    = vall[i].question;
            vall[i].sub_dly   = int'($urandom_range(0, 3));
            vall[i].tl_load   = 4'd9;
            vall[i].exp_flags = 3'b100;
            vall[i].exp_score = 4'(i + 1);
        end

        // Game 1: mixed correct / wrong / timeout / simultaneous rounds.
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("start_latency_q_req", {31'd0, q_req}, 32'd1);
        for (int i = 0; i < NUM_ROUNDS; i++) play_round(vecs[i], i, 1'b0);
        chk("g1_score", {28'd0, score}, 32'd5);
        chk("g1_round", {28'd0, round}, 32'd9);
        submit = 1'b1;
        tick;
        tick;
        submit = 1'b0;
        chk("g1_done_hold_game_over", {31'd0, game_over}, 32'd1);
        chk("g1_done_hold_score", {28'd0, score}, 32'd5);
        chk("g1_done_stop_flag", {31'd0, stop_flag}, 32'd1);

        // Game 2: every answer correct.
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("g2_start_score", {28'd0, score}, 32'd0);
        chk("g2_start_game_over", {31'd0, game_over}, 32'd0);
        for (int i = 0; i < NUM_ROUNDS; i++) play_round(vall[i], i, 1'b0);
        chk("g2_game_over", {31'd0, game_over}, 32'd1);
        chk("g2_score", {28'd0, score}, 32'd10);
        chk("g2_round", {28'd0, round}, 32'd9);

        // Restart from DONE, then reset during the fourth round's result.
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("g3_start_score", {28'd0, score}, 32'd0);
        chk("g3_start_round", {28'd0, round}, 32'd0);
        chk("g3_start_game_over", {31'd0, game_over}, 32'd0);
        for (int i = 0; i < 3; i++) play_round(vall[i], i, 1'b0);
        play_round(vall[3], 3, 1'b1);
        chk("g3_result_score", {28'd0, score}, 32'd4);
        reset  = 1'b1;
        start  = 1'b1;
        submit = 1'b1;
        tick;
        reset  = 1'b0;
        start  = 1'b0;
        submit = 1'b0;
        chk("rst_res_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
        chk("rst_res_score", {28'd0, score}, 32'd0);
        chk("rst_res_round", {28'd0, round}, 32'd0);
        chk("rst_res_stop_flag", {31'd0, stop_flag}, 32'd1);
        chk("rst_res_q_req", {31'd0, q_req}, 32'd0);
        chk("rst_res_flags", {29'd0, correct, wrong, timeout}, 32'd0);
        tick;
        chk("rst_res_no_q_req", {31'd0, q_req}, 32'd0);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("post_rst_start_q_req", {31'd0, q_req}, 32'd1);

        tick;
        tick;
        chk("sb_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
